// File: rtl/arbiter_capture_ctrl.sv
// Arbiter-PUF capture controller: clears the arbiter, launches a pulse into both delay chains, samples the winner and majority-votes it over C_REPEAT runs.
// Latency: ovalid rises 1 + C_REPEAT*(2*C_SETTLE+1) cycles after the accepting edge; one challenge in flight, oready low while busy.
// Backpressure: the result is held in DONE until ovalid&&iready; optional macro PUF_UNSTABLE_DETECT_EN enables the ounstable flag.
module arbiter_capture_ctrl #(
    parameter int C_LENGTH = 32,
    parameter int C_SETTLE = 8,
    parameter int C_REPEAT = 7
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          ivalid,
    input  logic [C_LENGTH-1:0]           ichallenge,
    output logic                          oready,
    output logic [C_LENGTH-1:0]           ochallenge,
    output logic                          opulse,
    output logic                          oarb_clr,
    input  logic                          iarb_resp,
    output logic                          ovalid,
    input  logic                          iready,
    output logic                          oresp,
    output logic [$clog2(C_REPEAT+1)-1:0] ovote,
    output logic                          ounstable
);

    // Vote counter is sized to hold C_REPEAT exactly, so it can never wrap.
    localparam int VW = $clog2(C_REPEAT + 1);
    // Phase counter only has to reach C_SETTLE-1.
    localparam int PW = (C_SETTLE > 1) ? $clog2(C_SETTLE) : 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(C_SETTLE - 1);
    localparam logic [VW-1:0] EVAL_LAST  = VW'(C_REPEAT - 1);
    localparam logic [VW-1:0] HALF       = VW'(C_REPEAT / 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  phase_cnt;
    logic [VW-1:0]  eval_cnt;
    logic           pulse_nxt;

    // State register; reset wins over every other input.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: each pulse phase lasts C_SETTLE cycles, SAMPLE lasts one.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ivalid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (phase_cnt == PHASE_LAST) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (phase_cnt == PHASE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (eval_cnt == EVAL_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CLEAR;
                end
            end
            DONE: begin
                // Only the registered ovalid can complete the handshake.
                if (ovalid && iready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pulse is high across LAUNCH and the SAMPLE cycle, low everywhere else.
    always_comb begin
        pulse_nxt = 1'b0;
        if ((state_nxt == LAUNCH) || (state_nxt == SAMPLE)) begin
            pulse_nxt = 1'b1;
        end
    end

    // Phase timer restarts on every state change and only runs in the timed phases.
    always_ff @(posedge iclk) begin
        if (irst) begin
            phase_cnt <= '0;
        end else if ((state_nxt != state) || (state != CLEAR && state != LAUNCH)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PW'(1);
        end
    end

    // Challenge latch, evaluation counter and vote accumulator.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ochallenge <= '0;
            ovote      <= '0;
            eval_cnt   <= '0;
        end else if (state == IDLE && ivalid) begin
            ochallenge <= ichallenge;
            ovote      <= '0;
            eval_cnt   <= '0;
        end else if (state == SAMPLE) begin
            ovote    <= ovote + VW'(iarb_resp);
            eval_cnt <= eval_cnt + VW'(1);
        end
    end

    // Chain-control and ready outputs registered from the next state so they never glitch.
    always_ff @(posedge iclk) begin
        if (irst) begin
            opulse   <= 1'b0;
            oarb_clr <= 1'b1;
            oready   <= 1'b1;
        end else begin
            opulse   <= pulse_nxt;
            oarb_clr <= ~pulse_nxt;
            oready   <= (state_nxt == IDLE);
        end
    end

    // Result stage: first DONE cycle resolves the final vote, then it holds until taken.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ovalid <= 1'b0;
            oresp  <= 1'b0;
        end else if (state == DONE && !ovalid) begin
            ovalid <= 1'b1;
            oresp  <= (ovote > HALF);
        end else if (state == DONE && iready) begin
            ovalid <= 1'b0;
            oresp  <= 1'b0;
        end
    end

`ifdef PUF_UNSTABLE_DETECT_EN
    localparam logic [VW-1:0] ALL_ONES_VOTE = VW'(C_REPEAT);

    // Flag a challenge whose evaluations disagreed; visible only while ovalid is high.
    always_ff @(posedge iclk) begin
        if (irst) begin
            ounstable <= 1'b0;
        end else if (state == DONE && !ovalid) begin
            ounstable <= (ovote != '0) && (ovote != ALL_ONES_VOTE);
        end else if (state == DONE && iready) begin
            ounstable <= 1'b0;
        end
    end
`else
    assign ounstable = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_capture_ctrl.sv
// Bench for arbiter_capture_ctrl: directed scenarios plus randomized traffic against a cycle-offset model.
// Latency: model predicts outputs from edges-since-acceptance arithmetic.
// Backpressure: iready is randomized; the model holds the result until it is taken.
module tb_arbiter_capture_ctrl;

    localparam int LEN    = 32;
    localparam int SETTLE = 2;
    localparam int REP    = 3;
    localparam int PER    = 2 * SETTLE + 1;
    localparam int VW     = $clog2(REP + 1);

    logic           iclk;
    logic           irst;
    logic           ivalid;
    logic [LEN-1:0] ichallenge;
    logic           oready;
    logic [LEN-1:0] ochallenge;
    logic           opulse;
    logic           oarb_clr;
    logic           iarb_resp;
    logic           ovalid;
    logic           iready;
    logic           oresp;
    logic [VW-1:0]  ovote;
    logic           ounstable;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    arbiter_capture_ctrl #(
        .C_LENGTH(LEN),
        .C_SETTLE(SETTLE),
        .C_REPEAT(REP)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .ivalid(ivalid),
        .ichallenge(ichallenge),
        .oready(oready),
        .ochallenge(ochallenge),
        .opulse(opulse),
        .oarb_clr(oarb_clr),
        .iarb_resp(iarb_resp),
        .ovalid(ovalid),
        .iready(iready),
        .oresp(oresp),
        .ovote(ovote),
        .ounstable(ounstable)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

`ifdef PUF_UNSTABLE_DETECT_EN
    localparam bit UNST_EN = 1'b1;
`else
    localparam bit UNST_EN = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a transaction is just "edges since acceptance".
    bit             m_busy = 0;
    bit             m_done = 0;
    int             m_t    = 0;
    int             m_vote = 0;
    logic [LEN-1:0] m_chal = '0;

    always @(posedge iclk) begin
        if (irst) begin
            m_busy = 0;
            m_done = 0;
            m_vote = 0;
            m_chal = '0;
            m_t    = 0;
        end else if (m_done) begin
            if (iready) m_done = 0;
        end else if (m_busy) begin
            m_t++;
            if ((m_t % PER) == 0 && m_t <= REP * PER) m_vote += int'(iarb_resp);
            if (m_t == REP * PER + 1) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (ivalid) begin
            m_busy = 1;
            m_chal = ichallenge;
            m_vote = 0;
            m_t    = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge iclk) begin
        if (chk_en) begin
            logic e_pulse;
            logic e_resp;
            logic e_unst;
            e_pulse = m_busy && (m_t < REP * PER) && ((m_t % PER) >= SETTLE);
            e_resp  = m_done && (m_vote > REP / 2);
            e_unst  = UNST_EN && m_done && (m_vote != 0) && (m_vote != REP);
            chk("oready",     32'(oready),    32'(!m_busy && !m_done));
            chk("opulse",     32'(opulse),    32'(e_pulse));
            chk("oarb_clr",   32'(oarb_clr),  32'(!e_pulse));
            chk("ovalid",     32'(ovalid),    32'(m_done));
            chk("oresp",      32'(oresp),     32'(e_resp));
            chk("ovote",      32'(ovote),     32'(m_vote));
            chk("ounstable",  32'(ounstable), 32'(e_unst));
            chk("ochallenge", ochallenge,     m_chal);
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    initial begin
        int k;
        int highs;
        int rises;
        int idx;
        logic prev;
        logic [2:0] pat;

        irst       = 1'b1;
        ivalid     = 1'b1;
        ichallenge = 32'hDEAD_BEEF;
        iarb_resp  = 1'b0;
        iready     = 1'b0;

        // Reset held two cycles with ivalid high: nothing accepted.
        tick();
        tick();
        irst   = 1'b0;
        ivalid = 1'b0;
        chk_en = 1;
        chk("rst_oready",  32'(oready),   32'd1);
        chk("rst_opulse",  32'(opulse),   32'd0);
        chk("rst_arb_clr", 32'(oarb_clr), 32'd1);
        chk("rst_ovalid",  32'(ovalid),   32'd0);
        chk("rst_ovote",   32'(ovote),    32'd0);
        chk("rst_chal",    ochallenge,    32'd0);

        // Constant winning arbiter, latency and pulse shape.
        iarb_resp  = 1'b1;
        ichallenge = 32'hA5A5_A5A5;
        ivalid     = 1'b1;
        tick();
        ivalid = 1'b0;
        chk("acc_oready", 32'(oready), 32'd0);
        k     = 0;
        highs = int'(opulse);
        rises = 0;
        prev  = opulse;
        while (!ovalid && k < 40) begin
            tick();
            k++;
            if (opulse && !prev) rises++;
            if (opulse) highs++;
            prev = opulse;
            chk("hold_chal", ochallenge, 32'hA5A5_A5A5);
        end
        chk("latency",     32'(k),         32'd16);
        chk("pulse_highs", 32'(highs),     32'd9);
        chk("pulse_rises", 32'(rises),     32'd3);
        chk("all1_resp",   32'(oresp),     32'd1);
        chk("all1_vote",   32'(ovote),     32'd3);
        chk("all1_unst",   32'(ounstable), 32'd0);
        iready = 1'b1;
        tick();
        iready = 1'b0;
        chk("hs_ovalid", 32'(ovalid), 32'd0);
        chk("hs_oready", 32'(oready), 32'd1);

        // Split vote 1,0,1 across the three SAMPLE cycles.
        ichallenge = 32'h0F0F_0F0F;
        ivalid     = 1'b1;
        tick();
        ivalid = 1'b0;
        pat    = 3'b101;
        k      = 1;
        while (!ovalid && k < 40) begin
            idx = (k - 1) / PER;
            if (idx > 2) idx = 2;
            iarb_resp = pat[idx];
            tick();
            k++;
        end
        chk("split_ovalid", 32'(ovalid),    32'd1);
        chk("split_resp",   32'(oresp),     32'd1);
        chk("split_vote",   32'(ovote),     32'd2);
        chk("split_unst",   32'(ounstable), 32'(UNST_EN));

        // Consumer stalls with a new request pending: everything held, nothing accepted.
        ivalid     = 1'b1;
        ichallenge = 32'h1234_5678;
        repeat (5) begin
            tick();
            chk("stall_ovalid", 32'(ovalid),  32'd1);
            chk("stall_vote",   32'(ovote),   32'd2);
            chk("stall_resp",   32'(oresp),   32'd1);
            chk("stall_ready",  32'(oready),  32'd0);
            chk("stall_chal",   ochallenge,   32'h0F0F_0F0F);
        end
        iready = 1'b1;
        tick();
        iready = 1'b0;
        chk("exit_ready", 32'(oready),  32'd1);
        chk("exit_chal",  ochallenge,   32'h0F0F_0F0F);
        tick();
        ivalid = 1'b0;
        chk("reacc_chal",  ochallenge,   32'h1234_5678);
        chk("reacc_ready", 32'(oready),  32'd0);

        // Reset during the second LAUNCH cycle of evaluation 2.
        iarb_resp = 1'b1;
        repeat (8) tick();
        chk("mid_pulse", 32'(opulse), 32'd1);
        irst = 1'b1;
        tick();
        irst = 1'b0;
        chk("mrst_pulse",  32'(opulse),   32'd0);
        chk("mrst_clr",    32'(oarb_clr), 32'd1);
        chk("mrst_vote",   32'(ovote),    32'd0);
        chk("mrst_ready",  32'(oready),   32'd1);
        chk("mrst_ovalid", 32'(ovalid),   32'd0);

        // Randomized traffic, checked every cycle by the model compare.
        for (int i = 0; i < 4000; i++) begin
            ivalid     = ($urandom_range(0, 3) == 0);
            iready     = ($urandom_range(0, 2) != 0);
            iarb_resp  = $urandom_range(0, 1) == 1;
            ichallenge = $urandom;
            irst       = ($urandom_range(0, 499) == 0);
            tick();
        end
        irst   = 1'b0;
        ivalid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
